adc_capture_ctrl: RTL and testbench

Capture controller between the SYZYGY ADC receiver output and the sample FIFO write port, entirely in the `adc_data_clk` domain. It runs a host-armed, fixed-length capture of `SAMPLE_COUNT` packed two-channel words. The capture optionally starts on a channel-1 level crossing. It reports busy, done and sticky overflow status for readback over host wires.

---
 rtl/adc_capture_pkg.sv | 29 ++
 rtl/adc_level_trigger.sv | 50 +++++
 rtl/adc_capture_ctrl.sv | 162 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture controller.
// State encoding, default counter width and the FIFO word packing order.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } cap_state_t;

    localparam int CNT_W_DEFAULT = 20;
    localparam int SAMPLE_W      = 16;
    localparam int WORD_W        = 32;

    // Channel 1 occupies the high half of the FIFO word, channel 2 the low half.
    localparam int CH1_LSB = 16;
    localparam int CH2_LSB = 0;

    function automatic logic [WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] ch1,
                                                    input logic [SAMPLE_W-1:0] ch2);
        logic [WORD_W-1:0] w;
        w = '0;
        w[CH1_LSB +: SAMPLE_W] = ch1;
        w[CH2_LSB +: SAMPLE_W] = ch2;
        return w;
    endfunction

endpackage

// File: rtl/adc_level_trigger.sv
// Channel-1 level-crossing detector used when ADC_LEVEL_TRIGGER_EN is defined.
// Keeps the previous valid sample and flags a crossing of a signed threshold.
module adc_level_trigger
    import adc_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sample_vld,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                rising,
    output logic                hit
);

    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [SAMPLE_W-1:0] level_s;
    logic signed [SAMPLE_W-1:0] prev_p0;
    logic                       vld_p0;

    assign cur_s   = $signed(sample);
    assign level_s = $signed(level);

    function automatic logic crossed(input logic signed [SAMPLE_W-1:0] prev,
                                     input logic signed [SAMPLE_W-1:0] cur,
                                     input logic signed [SAMPLE_W-1:0] thr,
                                     input logic                       up);
        if (up)
            return (prev < thr) && (cur >= thr);
        else
            return (prev > thr) && (cur <= thr);
    endfunction

    // Previous valid sample; arming invalidates it so a stale sample cannot fire
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (sample_vld) begin
            prev_p0 <= cur_s;
            vld_p0  <= 1'b1;
        end
    end

    // A hit needs a valid current sample and a valid predecessor
    always_comb begin
        hit = sample_vld && vld_p0 && crossed(prev_p0, cur_s, level_s, rising);
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Host-armed fixed-length capture from the SYZYGY ADC receiver into the sample FIFO.
// Runs entirely in the adc_data_clk domain. Define ADC_LEVEL_TRIGGER_EN to start
// the capture on a channel-1 level crossing instead of the first valid sample.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic [CNT_W-1:0]   sample_count,
    input  logic [15:0]        adc_data_1,
    input  logic [15:0]        adc_data_2,
    input  logic               data_valid,
    input  logic               rdy,
    input  logic               fifo_prog_full,
    input  logic               fifo_busy,
    input  logic [15:0]        trig_level,
    input  logic               trig_rising,
    output logic [31:0]        fifo_din,
    output logic               fifo_wr_en,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [CNT_W-1:0]   words_written
);

    cap_state_t        state;
    cap_state_t        state_nx;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  target_nx;
    logic [CNT_W-1:0]  count_nx;
    logic [CNT_W-1:0]  count_inc;
    logic              ovf_nx;
    logic              wr_nx;
    logic              take;
    logic              sample_ok;
    logic              stop_req;
    logic              arm_ok;
    logic              arm_accept;
    logic              trig_hit;

    logic              wr_en_p1;
    logic [31:0]       din_p1;
    logic [CNT_W-1:0]  words_p1;
    logic              ovf_p1;
    logic              busy_p1;
    logic              done_p1;

    // A sample is usable only when the receiver is aligned and the SERDES is ready
    assign sample_ok = data_valid & rdy;
    assign arm_ok    = arm & rdy & ~fifo_busy;
    // A FIFO reset during an active capture is treated exactly like a host abort
    assign stop_req  = abort | (fifo_busy & ((state == ST_WAIT_TRIG) | (state == ST_CAPTURE)));
    assign count_inc = words_p1 + CNT_W'(1);

`ifdef ADC_LEVEL_TRIGGER_EN
    adc_level_trigger u_trig (
        .clk        (clk),
        .reset      (reset),
        .clear      (arm_accept),
        .sample_vld (sample_ok),
        .sample     (adc_data_1),
        .level      (trig_level),
        .rising     (trig_rising),
        .hit        (trig_hit)
    );
`else
    logic unused_trig;
    assign unused_trig = ^{trig_level, trig_rising};
    assign trig_hit    = sample_ok;
`endif

    // Next-state, write decision and status updates
    always_comb begin
        state_nx   = state;
        target_nx  = target;
        count_nx   = words_p1;
        ovf_nx     = ovf_p1;
        wr_nx      = 1'b0;
        arm_accept = 1'b0;
        take       = 1'b0;
        if (stop_req) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm_ok) begin
                        arm_accept = 1'b1;
                        target_nx  = sample_count;
                        count_nx   = '0;
                        ovf_nx     = 1'b0;
                        state_nx   = (sample_count == '0) ? ST_DONE : ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit) begin
                        take     = 1'b1;
                        state_nx = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    take = sample_ok;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
            if (take) begin
                if (fifo_prog_full) begin
                    ovf_nx = 1'b1;
                end else begin
                    wr_nx    = 1'b1;
                    count_nx = count_inc;
                    if (count_inc == target)
                        state_nx = ST_DONE;
                end
            end
        end
    end

    // State, target and host-visible status, updated on the same edge as the write
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            target   <= '0;
            words_p1 <= '0;
            ovf_p1   <= 1'b0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            state    <= state_nx;
            target   <= target_nx;
            words_p1 <= count_nx;
            ovf_p1   <= ovf_nx;
            busy_p1  <= (state_nx == ST_WAIT_TRIG) || (state_nx == ST_CAPTURE);
            done_p1  <= (state_nx == ST_DONE);
        end
    end

    // ---- stage p1: registered FIFO write port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_p1 <= 1'b0;
            din_p1   <= '0;
        end else begin
            wr_en_p1 <= wr_nx;
            if (wr_nx)
                din_p1 <= pack_word(adc_data_1, adc_data_2);
        end
    end

    assign fifo_wr_en    = wr_en_p1;
    assign fifo_din      = din_p1;
    assign busy          = busy_p1;
    assign done          = done_p1;
    assign overflow      = ovf_p1;
    assign words_written = words_p1;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl with a behavioural reference model.
// Build with ADC_LEVEL_TRIGGER_EN defined to exercise the level-trigger variant.
module tb_adc_capture_ctrl;

    localparam int CW   = 20;
    localparam int MAXN = 80;
`ifdef ADC_LEVEL_TRIGGER_EN
    localparam bit LEVEL_TRIG = 1'b1;
`else
    localparam bit LEVEL_TRIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, arm, abort, data_valid, rdy, fifo_prog_full, fifo_busy, trig_rising;
    logic [CW-1:0] sample_count;
    logic [15:0]   adc_data_1, adc_data_2, trig_level;
    logic [31:0]   fifo_din;
    logic          fifo_wr_en, busy, done, overflow;
    logic [CW-1:0] words_written;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        logic [31:0] word;
    } wr_t;

    // stimulus per cycle
    logic [15:0]   st_d1 [MAXN];
    logic [15:0]   st_d2 [MAXN];
    logic [CW-1:0] st_sc [MAXN];
    bit            st_dv [MAXN], st_pf [MAXN], st_arm [MAXN], st_ab [MAXN];
    bit            st_fb [MAXN], st_rdy [MAXN], st_rst [MAXN];

    // observations and expectations, index j = after the j-th stimulus cycle
    logic          o_wr [MAXN+1], o_busy [MAXN+1], o_done [MAXN+1], o_ovf [MAXN+1];
    logic [31:0]   o_din [MAXN+1];
    logic [CW-1:0] o_ww [MAXN+1];
    bit            e_wr [MAXN+1], e_busy [MAXN+1], e_done [MAXN+1], e_ovf [MAXN+1];
    logic [31:0]   e_din [MAXN+1];
    logic [CW-1:0] e_ww [MAXN+1];
    wr_t           a_q[$];
    wr_t           e_q[$];

    adc_capture_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .arm            (arm),
        .abort          (abort),
        .sample_count   (sample_count),
        .adc_data_1     (adc_data_1),
        .adc_data_2     (adc_data_2),
        .data_valid     (data_valid),
        .rdy            (rdy),
        .fifo_prog_full (fifo_prog_full),
        .fifo_busy      (fifo_busy),
        .trig_level     (trig_level),
        .trig_rising    (trig_rising),
        .fifo_din       (fifo_din),
        .fifo_wr_en     (fifo_wr_en),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .words_written  (words_written)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int k = 0; k < MAXN; k++) begin
            st_d1[k] = 16'(50 + k);
            st_d2[k] = 16'(3 * k);
            st_sc[k] = '0;
            st_dv[k] = 1'b1; st_pf[k] = 1'b0; st_arm[k] = 1'b0; st_ab[k] = 1'b0;
            st_fb[k] = 1'b0; st_rdy[k] = 1'b1; st_rst[k] = 1'b0;
        end
        st_rst[0]   = 1'b1;
        trig_level  = 16'd0;
        trig_rising = 1'b1;
    endtask

    // Reference: capture rules applied cycle by cycle to the stimulus list
    task automatic model_run(input int n);
        bit active, started, done_m, ovf, pv, wr, ok, go, xing;
        int cnt, tgt;
        logic signed [15:0] prev, cur, lvl;
        logic [31:0] din;
        wr_t w;
        active = 0; started = 0; done_m = 0; ovf = 0; pv = 0; cnt = 0; tgt = 0;
        prev = '0; din = '0; lvl = $signed(trig_level);
        e_q.delete();
        for (int k = 0; k < n; k++) begin
            ok = st_dv[k] && st_rdy[k];
            wr = 1'b0;
            cur = $signed(st_d1[k]);
            if (st_rst[k]) begin
                active = 0; started = 0; done_m = 0; ovf = 0; pv = 0; cnt = 0; din = '0;
            end else if (st_ab[k] || (active && st_fb[k])) begin
                active = 0; done_m = 0;
            end else if (!active) begin
                if (st_arm[k] && st_rdy[k] && !st_fb[k]) begin
                    tgt = int'(st_sc[k]); cnt = 0; ovf = 0; pv = 0; started = 0;
                    active = (tgt != 0); done_m = (tgt == 0);
                end
            end else if (ok) begin
                xing = trig_rising ? (prev < lvl && cur >= lvl) : (prev > lvl && cur <= lvl);
                go = started || !LEVEL_TRIG || (pv && xing);
                pv = 1; prev = cur;
                if (go) begin
                    started = 1;
                    if (st_pf[k]) ovf = 1;
                    else begin
                        wr = 1; cnt++; din = {st_d1[k], st_d2[k]};
                        w.cyc = k + 1; w.word = din; e_q.push_back(w);
                        if (cnt == tgt) begin active = 0; done_m = 1; end
                    end
                end
            end
            e_wr[k+1] = wr; e_busy[k+1] = active; e_done[k+1] = done_m;
            e_ovf[k+1] = ovf; e_ww[k+1] = CW'(cnt); e_din[k+1] = din;
        end
    endtask

    // Drive the stimulus list and record the outputs once per cycle
    task automatic run_stim(input int n);
        wr_t w;
        a_q.delete();
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o_wr[k] = fifo_wr_en; o_din[k] = fifo_din; o_busy[k] = busy;
                o_done[k] = done; o_ovf[k] = overflow; o_ww[k] = words_written;
                if (fifo_wr_en === 1'b1) begin
                    w.cyc = k; w.word = fifo_din; a_q.push_back(w);
                end
            end
            if (k < n) begin
                reset = st_rst[k]; arm = st_arm[k]; abort = st_ab[k]; sample_count = st_sc[k];
                adc_data_1 = st_d1[k]; adc_data_2 = st_d2[k]; data_valid = st_dv[k];
                rdy = st_rdy[k]; fifo_prog_full = st_pf[k]; fifo_busy = st_fb[k];
            end else begin
                reset = 1'b0; arm = 1'b0; abort = 1'b0; data_valid = 1'b0; fifo_busy = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        clear_stim();
        st_rst[1] = 1'b1; st_rst[2] = 1'b1; st_arm[1] = 1'b1; st_sc[1] = 20'd5; st_pf[2] = 1'b1;
        run_stim(3);
        checks++; if (o_wr[3] !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", o_wr[3]); end
        checks++; if (o_din[3] !== 32'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", o_din[3]); end
        checks++; if (o_busy[3] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy[3]); end
        checks++; if (o_done[3] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done[3]); end
        checks++; if (o_ovf[3] !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", o_ovf[3]); end
        checks++; if (o_ww[3] !== '0) begin failures++; $display("FAIL reset_words got=%0d exp=0", o_ww[3]); end
    endtask

`ifndef ADC_LEVEL_TRIGGER_EN
    task automatic test_immediate();
        int last;
        clear_stim();
        st_arm[1] = 1'b1; st_sc[1] = 20'd8; st_dv[1] = 1'b0;
        for (int k = 2; k <= 22; k++) begin st_d1[k] = 16'(k - 2); st_d2[k] = 16'(k - 2); end
        model_run(26);
        run_stim(26);
        checks++; if (a_q.size() != 8) begin failures++; $display("FAIL imm_count got=%0d exp=8", a_q.size()); end
        for (int i = 0; i < a_q.size() && i < 8; i++) begin
            checks++;
            if (a_q[i].word !== {16'(i), 16'(i)} || a_q[i].cyc != i + 3) begin
                failures++; $display("FAIL imm_word%0d got=%h@%0d exp=%h@%0d", i, a_q[i].word, a_q[i].cyc, {16'(i), 16'(i)}, i + 3);
            end
        end
        last = 10;
        checks++; if (o_done[last] !== 1'b1 || o_ww[last] !== 20'd8) begin failures++; $display("FAIL imm_done_last got done=%b ww=%0d exp done=1 ww=8", o_done[last], o_ww[last]); end
        checks++; if (o_done[last-1] !== 1'b0 || o_busy[last-1] !== 1'b1) begin failures++; $display("FAIL imm_busy_before got done=%b busy=%b exp 0 1", o_done[last-1], o_busy[last-1]); end
        checks++; if (o_wr[last+1] !== 1'b0) begin failures++; $display("FAIL imm_no_extra got=%b exp=0", o_wr[last+1]); end
        checks++; if (a_q.size() != e_q.size()) begin failures++; $display("FAIL imm_model_count got=%0d exp=%0d", a_q.size(), e_q.size()); end
    endtask
`endif

`ifdef ADC_LEVEL_TRIGGER_EN
    task automatic test_level_trigger();
        clear_stim();
        trig_level = 16'd100;
        st_arm[1] = 1'b1; st_sc[1] = 20'd3;
        for (int k = 2; k < MAXN; k++) st_d1[k] = 16'(120);
        for (int k = 2; k <= 8; k++) st_d1[k] = 16'(90 + 5 * (k - 2));
        run_stim(14);
        checks++; if (a_q.size() != 3) begin failures++; $display("FAIL lvl_count got=%0d exp=3", a_q.size()); end
        for (int i = 0; i < a_q.size() && i < 3; i++) begin
            checks++;
            if (a_q[i].word[31:16] !== 16'(100 + 5 * i)) begin
                failures++; $display("FAIL lvl_ch1_%0d got=%0d exp=%0d", i, a_q[i].word[31:16], 100 + 5 * i);
            end
        end
        checks++; if (o_done[14] !== 1'b1) begin failures++; $display("FAIL lvl_done got=%b exp=1", o_done[14]); end
        trig_rising = 1'b0;
        run_stim(14);
        checks++; if (a_q.size() != 0) begin failures++; $display("FAIL lvl_fall_writes got=%0d exp=0", a_q.size()); end
        checks++; if (o_busy[14] !== 1'b1) begin failures++; $display("FAIL lvl_fall_busy got=%b exp=1", o_busy[14]); end
    endtask
`endif

    task automatic test_backpressure();
        clear_stim();
        st_arm[1] = 1'b1; st_sc[1] = 20'd10; st_d1[2] = 16'hFC18;
        st_pf[5] = 1'b1; st_pf[6] = 1'b1; st_pf[7] = 1'b1;
        model_run(24);
        run_stim(24);
        checks++; if (a_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", a_q.size()); end
        checks++; if (o_ovf[24] !== 1'b1 || o_done[24] !== 1'b1 || o_ww[24] !== 20'd10) begin
            failures++; $display("FAIL bp_final got ovf=%b done=%b ww=%0d exp 1 1 10", o_ovf[24], o_done[24], o_ww[24]); end
        checks++; if (o_wr[6] !== 1'b0 || o_wr[7] !== 1'b0 || o_wr[8] !== 1'b0) begin
            failures++; $display("FAIL bp_skipped got=%b%b%b exp=000", o_wr[6], o_wr[7], o_wr[8]); end
        checks++; if (a_q.size() != e_q.size()) begin failures++; $display("FAIL bp_model_count got=%0d exp=%0d", a_q.size(), e_q.size()); end
        for (int i = 0; i < a_q.size() && i < e_q.size(); i++) begin
            checks++;
            if (a_q[i].cyc != e_q[i].cyc || a_q[i].word !== e_q[i].word) begin
                failures++; $display("FAIL bp_word%0d got=%h@%0d exp=%h@%0d", i, a_q[i].word, a_q[i].cyc, e_q[i].word, e_q[i].cyc);
            end
        end
    endtask

    task automatic test_abort();
        int c4, n;
        clear_stim();
        st_arm[1] = 1'b1; st_sc[1] = 20'd16; st_d1[2] = 16'hFC18; st_pf[3] = 1'b1;
        model_run(30);
        c4 = e_q[3].cyc - 1;
        st_ab[c4+1] = 1'b1;
        st_arm[c4+4] = 1'b1; st_sc[c4+4] = 20'd5; st_d1[c4+5] = 16'hFC18;
        n = c4 + 12;
        model_run(n);
        run_stim(n);
        checks++; if (o_wr[c4+2] !== 1'b0 || o_busy[c4+2] !== 1'b0 || o_done[c4+2] !== 1'b0) begin
            failures++; $display("FAIL abort_stop got wr=%b busy=%b done=%b exp 0 0 0", o_wr[c4+2], o_busy[c4+2], o_done[c4+2]); end
        checks++; if (o_ww[c4+2] !== 20'd4 || o_ovf[c4+2] !== 1'b1) begin
            failures++; $display("FAIL abort_retain got ww=%0d ovf=%b exp 4 1", o_ww[c4+2], o_ovf[c4+2]); end
        checks++; if (o_wr[c4+3] !== 1'b0 || o_wr[c4+4] !== 1'b0) begin
            failures++; $display("FAIL abort_quiet got=%b%b exp=00", o_wr[c4+3], o_wr[c4+4]); end
        checks++; if (o_ww[c4+5] !== '0 || o_ovf[c4+5] !== 1'b0 || o_busy[c4+5] !== 1'b1) begin
            failures++; $display("FAIL rearm_clear got ww=%0d ovf=%b busy=%b exp 0 0 1", o_ww[c4+5], o_ovf[c4+5], o_busy[c4+5]); end
        checks++; if (a_q.size() != e_q.size()) begin failures++; $display("FAIL abort_model_count got=%0d exp=%0d", a_q.size(), e_q.size()); end
    endtask

    task automatic test_gating();
        int early;
        clear_stim();
        st_arm[1] = 1'b1; st_sc[1] = 20'd5; st_rdy[1] = 1'b0; st_rdy[2] = 1'b0;
        st_arm[4] = 1'b1; st_sc[4] = 20'd0;
        st_arm[7] = 1'b1; st_sc[7] = 20'd20; st_d1[8] = 16'hFC18; st_fb[14] = 1'b1;
        st_arm[18] = 1'b1; st_sc[18] = 20'd20; st_d1[19] = 16'hFC18; st_pf[21] = 1'b1;
        st_rst[24] = 1'b1;
        model_run(27);
        run_stim(27);
        checks++; if (o_busy[2] !== 1'b0 || o_busy[3] !== 1'b0) begin failures++; $display("FAIL gate_rdy got busy=%b%b exp=00", o_busy[2], o_busy[3]); end
        checks++; if (o_done[5] !== 1'b1 || o_busy[5] !== 1'b0 || o_ww[5] !== '0) begin
            failures++; $display("FAIL gate_zero got done=%b busy=%b ww=%0d exp 1 0 0", o_done[5], o_busy[5], o_ww[5]); end
        early = 0;
        foreach (a_q[i]) if (a_q[i].cyc <= 8) early++;
        checks++; if (early != 0) begin failures++; $display("FAIL gate_no_writes got=%0d exp=0", early); end
        checks++; if (o_busy[15] !== 1'b0 || o_done[15] !== 1'b0 || o_wr[15] !== 1'b0 || o_wr[16] !== 1'b0) begin
            failures++; $display("FAIL gate_fifo_busy got busy=%b done=%b wr=%b%b exp 0 0 00", o_busy[15], o_done[15], o_wr[15], o_wr[16]); end
        checks++; if (o_ww[15] !== e_ww[15]) begin failures++; $display("FAIL gate_fb_words got=%0d exp=%0d", o_ww[15], e_ww[15]); end
        checks++; if (o_wr[25] !== 1'b0 || o_din[25] !== 32'h0 || o_busy[25] !== 1'b0 || o_done[25] !== 1'b0 || o_ovf[25] !== 1'b0 || o_ww[25] !== '0) begin
            failures++; $display("FAIL gate_reset got wr=%b din=%h busy=%b done=%b ovf=%b ww=%0d exp all 0", o_wr[25], o_din[25], o_busy[25], o_done[25], o_ovf[25], o_ww[25]); end
    endtask

    task automatic test_random();
        int n;
        n = 60;
        for (int it = 0; it < 8; it++) begin
            clear_stim();
            trig_rising = 1'($urandom_range(0, 1));
            for (int k = 1; k < n; k++) begin
                st_d1[k]  = 16'(int'($urandom_range(0, 16)) - 8);
                st_d2[k]  = 16'($urandom);
                st_dv[k]  = ($urandom_range(0, 99) < 75);
                st_rdy[k] = ($urandom_range(0, 99) < 92);
                st_pf[k]  = ($urandom_range(0, 99) < 20);
                st_arm[k] = ($urandom_range(0, 99) < 12);
                st_sc[k]  = CW'($urandom_range(0, 12));
                st_ab[k]  = ($urandom_range(0, 99) < 3);
                st_fb[k]  = ($urandom_range(0, 99) < 3);
            end
            model_run(n);
            run_stim(n);
            for (int j = 1; j <= n; j++) begin
                checks++;
                if (o_wr[j] !== e_wr[j] || o_busy[j] !== e_busy[j] || o_done[j] !== e_done[j] ||
                    o_ovf[j] !== e_ovf[j] || o_ww[j] !== e_ww[j] || (e_wr[j] && o_din[j] !== e_din[j])) begin
                    failures++;
                    $display("FAIL rand%0d_cyc%0d got wr=%b din=%h busy=%b done=%b ovf=%b ww=%0d exp wr=%b din=%h busy=%b done=%b ovf=%b ww=%0d",
                             it, j, o_wr[j], o_din[j], o_busy[j], o_done[j], o_ovf[j], o_ww[j],
                             e_wr[j], e_din[j], e_busy[j], e_done[j], e_ovf[j], e_ww[j]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; sample_count = '0;
        adc_data_1 = '0; adc_data_2 = '0; data_valid = 1'b0; rdy = 1'b0;
        fifo_prog_full = 1'b0; fifo_busy = 1'b0; trig_level = '0; trig_rising = 1'b1;
        test_reset();
`ifndef ADC_LEVEL_TRIGGER_EN
        test_immediate();
`else
        test_level_trigger();
`endif
        test_backpressure();
        test_abort();
        test_gating();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
